neuron_driver: RTL and testbench
================================

Name: neuron_driver

Overview:
Front-end initiator for a single neuron instance. It accepts a serial stream of fixed-point samples over a valid/ready handshake and assembles them into a NUM_INPUTS-entry parallel vector. It fires a one-cycle inputs_ready pulse to the neuron, holds the vector stable until the neuron's output_ready pulse, then captures the result and presents it downstream on a valid/ready handshake. Sample width is INTEGER_WIDTH+FRACTION_WIDTH, signed, with the binary point between bit 0 and bit -1, from the shared include.svh.

Parameters:
NUM_INPUTS, 16, entries per vector; must be >= 2.
TIMEOUT_CYCLES, 64, maximum WAIT-state cycles before the watchdog fires (used only with the optional feature); must be >= NUM_INPUTS+3.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high.
in_valid  in  1  upstream sample valid.
in_data  in  signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]  upstream sample.
in_ready  out  1  driver can accept a sample.
inputs  out  signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] x NUM_INPUTS (unpacked)  vector to the neuron.
inputs_ready  out  1  one-cycle start pulse to the neuron.
neuron_out  in  signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]  neuron result.
neuron_output_ready  in  1  one-cycle neuron done pulse.
result  out  signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]  captured result.
result_valid  out  1  result available downstream.
result_ready  in  1  downstream accepts result.
busy  out  1  high in any state other than FILL.
timeout_error  out  1  sticky watchdog flag.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state = FILL, fill index = 0, all inputs[] = 0, result = 0.
  - inputs_ready, result_valid, busy and timeout_error = 0.
- Fill index width is $clog2(NUM_INPUTS).
- FILL:
  - in_ready = 1.
  - On in_valid & in_ready: inputs[idx] <= in_data.
  - If idx == NUM_INPUTS-1: idx <= 0 and state -> FIRE. Otherwise idx <= idx+1.
  - Without in_valid: hold state and index.
- FIRE (exactly one cycle):
  - inputs_ready = 1 (registered from the state), in_ready = 0.
  - state -> WAIT unconditionally.
  - inputs_ready rises on the cycle after the last sample is accepted.
- WAIT:
  - in_ready = 0; inputs[] held constant.
  - Stability is mandatory: the neuron indexes inputs[] serially for NUM_INPUTS cycles.
  - On neuron_output_ready: result <= neuron_out, state -> PRESENT.
- PRESENT:
  - result_valid = 1; result held; in_ready = 0.
  - On result_ready: state -> FILL on the next cycle.
  - If result_ready is high in the same cycle result_valid first asserts, the transfer completes in that cycle (one-cycle PRESENT).
- The inputs[] vector keeps its last contents after returning to FILL. Entries are overwritten individually as new samples arrive.
- neuron_output_ready outside WAIT is ignored: no capture, no state change.
- inputs_ready is never asserted outside FIRE and never for more than one consecutive cycle.
- busy = (state != FILL).
- Minimum vector-to-result latency = NUM_INPUTS accept cycles + 1 (FIRE) + neuron latency + 1 (capture).
- Downstream backpressure stalls the block in PRESENT. No new samples are accepted while stalled (single-vector buffering, no overlap).
- State encoding: FILL, FIRE, WAIT, PRESENT in a 2-bit enum. An illegal state returns to FILL.

Optional Feature:
Macro NEURON_DRIVER_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no neuron_output_ready: timeout_error <= 1 (sticky until reset), result unchanged, state -> FILL, fill index = 0, no result_valid.
  - If neuron_output_ready arrives on the same cycle the count reaches TIMEOUT_CYCLES, the output_ready wins: normal capture, no error.
- Not defined:
  - No counter logic.
  - timeout_error is tied to 0.
  - WAIT waits indefinitely.

Test Plan:
1. Reset, then feed 16 samples of 1.0 back-to-back; a responder model returns 51.0 after 18 cycles -> inputs_ready pulses once, on the cycle after the 16th accept; inputs[] stays all 1.0 throughout WAIT; result = 51.0 with result_valid until accepted; in_ready is 0 from FIRE until back in FILL.
2. Samples with random in_valid gaps, values 0..15 -> inputs[i] = i at FIRE; idx wraps to 0; no extra inputs_ready.
3. Hold result_ready low for 10 cycles in PRESENT while in_valid = 1 -> result stable, in_ready = 0, no sample lost. Then result_ready = 1 -> FILL next cycle, and the next sample lands in inputs[0].
4. Spurious neuron_output_ready pulses during FILL and PRESENT -> no capture, no state change. result_ready high coincident with result_valid rising -> one-cycle PRESENT.
5. Assert reset during WAIT and again during PRESENT -> all outputs 0 immediately (asynchronous); the next vector completes normally.
6. With NEURON_DRIVER_TIMEOUT_EN, TIMEOUT_CYCLES = 64, and the responder silent -> timeout_error = 1 after 64 WAIT cycles, return to FILL, no result_valid. Responder pulsing on exactly the 64th cycle -> capture, timeout_error = 0. Without the macro, the silent responder leaves the block in WAIT indefinitely and timeout_error stays 0.

Source files
------------

// File: rtl/neuron_driver.sv
// -----------------------------------------------------------------------------
// neuron_driver
//   Front-end initiator for a single neuron. Collects NUM_INPUTS serial samples
//   over a valid/ready handshake into a parallel vector, issues a one-cycle
//   inputs_ready start pulse, holds the vector stable while the neuron works,
//   captures the neuron's result on output_ready and presents it downstream on
//   a valid/ready handshake.
//
//   Sample format: signed fixed point [INTEGER_WIDTH-1:-FRACTION_WIDTH], with
//   the binary point between bit 0 and bit -1. The widths normally come from
//   the shared include.svh; local fallbacks apply when it has not been read.
//
//   Optional build macro NEURON_DRIVER_TIMEOUT_EN adds a WAIT-state watchdog
//   that abandons the vector after TIMEOUT_CYCLES and sets a sticky
//   timeout_error. Without it, timeout_error is tied low and WAIT never ends
//   except on output_ready.
//
// Ports:
//   clock, reset          rising-edge clock; asynchronous active-high reset
//   in_valid/in_data      upstream sample stream
//   in_ready              high only while collecting (FILL)
//   inputs[NUM_INPUTS]    vector to the neuron, stable from FIRE through WAIT
//   inputs_ready          one-cycle start pulse (FIRE state)
//   neuron_out            neuron result
//   neuron_output_ready   one-cycle neuron done pulse, honoured only in WAIT
//   result/result_valid   captured result, downstream handshake
//   result_ready          downstream accept
//   busy                  high in every state except FILL
//   timeout_error         sticky watchdog flag
// -----------------------------------------------------------------------------
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif
`ifndef FRACTION_WIDTH
`define FRACTION_WIDTH 8
`endif

module neuron_driver #(
  parameter int unsigned NUM_INPUTS     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic                                            in_valid,
  input  logic signed [`INTEGER_WIDTH-1:-`FRACTION_WIDTH] in_data,
  output logic                                            in_ready,
  output logic signed [`INTEGER_WIDTH-1:-`FRACTION_WIDTH] inputs [NUM_INPUTS],
  output logic                                            inputs_ready,
  input  logic signed [`INTEGER_WIDTH-1:-`FRACTION_WIDTH] neuron_out,
  input  logic                                            neuron_output_ready,
  output logic signed [`INTEGER_WIDTH-1:-`FRACTION_WIDTH] result,
  output logic                                            result_valid,
  input  logic                                            result_ready,
  output logic                                            busy,
  output logic                                            timeout_error
);

  localparam int unsigned IDX_W = $clog2(NUM_INPUTS);

  if (NUM_INPUTS < 2) begin : g_bad_num_inputs
    $error("neuron_driver: NUM_INPUTS must be >= 2");
  end
  if (TIMEOUT_CYCLES < NUM_INPUTS + 3) begin : g_bad_timeout
    $error("neuron_driver: TIMEOUT_CYCLES must be >= NUM_INPUTS+3");
  end

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    FIRE    = 2'd1,
    WAIT    = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;

`ifdef NEURON_DRIVER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_count;
`endif

  // Handshake and status outputs are pure decodes of the state register, so
  // they change only on clock edges (or reset) and never glitch on inputs.
  always_comb begin
    in_ready     = (state == FILL);
    inputs_ready = (state == FIRE);
    result_valid = (state == PRESENT);
    busy         = (state != FILL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= FILL;
      idx    <= '0;
      result <= '0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        inputs[i] <= '0;
      end
`ifdef NEURON_DRIVER_TIMEOUT_EN
      wd_count      <= '0;
      timeout_error <= 1'b0;
`endif
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            inputs[idx] <= in_data;
            if (idx == IDX_W'(NUM_INPUTS - 1)) begin
              idx   <= '0;
              state <= FIRE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        FIRE: begin
`ifdef NEURON_DRIVER_TIMEOUT_EN
          wd_count <= '0;
`endif
          state <= WAIT;
        end

        WAIT: begin
          if (neuron_output_ready) begin
            result <= neuron_out;
            state  <= PRESENT;
          end
`ifdef NEURON_DRIVER_TIMEOUT_EN
          // wd_count holds completed WAIT cycles; comparing against
          // TIMEOUT_CYCLES-1 fires on the cycle the count reaches the limit.
          // output_ready in that same cycle takes priority above.
          else if (wd_count == WD_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_error <= 1'b1;
            idx           <= '0;
            state         <= FILL;
          end else begin
            wd_count <= wd_count + 1'b1;
          end
`endif
        end

        PRESENT: begin
          if (result_ready) begin
            state <= FILL;
          end
        end

        default: begin
          state <= FILL;
        end
      endcase
    end
  end

`ifndef NEURON_DRIVER_TIMEOUT_EN
  always_comb begin
    timeout_error = 1'b0;
  end
`endif

endmodule

// File: tb/tb_neuron_driver.sv
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif
`ifndef FRACTION_WIDTH
`define FRACTION_WIDTH 8
`endif

module tb_neuron_driver;

  localparam int N  = 16;
  localparam int TO = 64;
  localparam int IW = `INTEGER_WIDTH;
  localparam int FW = `FRACTION_WIDTH;

  typedef logic signed [IW-1:-FW] sample_t;

  logic    clock = 1'b0;
  logic    reset;
  logic    in_valid;
  sample_t in_data;
  logic    in_ready;
  sample_t inputs [N];
  logic    inputs_ready;
  sample_t neuron_out;
  logic    neuron_output_ready;
  sample_t result;
  logic    result_valid;
  logic    result_ready;
  logic    busy;
  logic    timeout_error;

  int checks;
  int errors;

  neuron_driver #(.NUM_INPUTS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock               (clock),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_data             (in_data),
    .in_ready            (in_ready),
    .inputs              (inputs),
    .inputs_ready        (inputs_ready),
    .neuron_out          (neuron_out),
    .neuron_output_ready (neuron_output_ready),
    .result              (result),
    .result_valid        (result_valid),
    .result_ready        (result_ready),
    .busy                (busy),
    .timeout_error       (timeout_error)
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Transaction-level reference: what has been collected, whether a start has
  // been issued, how long the neuron has been busy, and what result is held.
  // ---------------------------------------------------------------------------
  localparam int P_COLLECT = 0;
  localparam int P_START   = 1;
  localparam int P_COMPUTE = 2;
  localparam int P_OFFER   = 3;

  int      m_phase;
  int      m_count;
  int      m_wait;
  sample_t m_vec [N];
  sample_t m_result;
  logic    m_err;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase  <= P_COLLECT;
      m_count  <= 0;
      m_wait   <= 0;
      m_result <= '0;
      m_err    <= 1'b0;
      for (int i = 0; i < N; i++) m_vec[i] <= '0;
    end else begin
      case (m_phase)
        P_COLLECT: if (in_valid) begin
          m_vec[m_count] <= in_data;
          if (m_count + 1 == N) begin
            m_count <= 0;
            m_phase <= P_START;
          end else begin
            m_count <= m_count + 1;
          end
        end
        P_START: begin
          m_wait  <= 0;
          m_phase <= P_COMPUTE;
        end
        P_COMPUTE: begin
          m_wait <= m_wait + 1;
          if (neuron_output_ready) begin
            m_result <= neuron_out;
            m_phase  <= P_OFFER;
          end
`ifdef NEURON_DRIVER_TIMEOUT_EN
          else if (m_wait + 1 == TO) begin
            m_err   <= 1'b1;
            m_count <= 0;
            m_phase <= P_COLLECT;
          end
`endif
        end
        default: if (result_ready) m_phase <= P_COLLECT;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic compare;
    int bad;
    chk("in_ready",      in_ready,      m_phase == P_COLLECT);
    chk("busy",          busy,          m_phase != P_COLLECT);
    chk("inputs_ready",  inputs_ready,  m_phase == P_START);
    chk("result_valid",  result_valid,  m_phase == P_OFFER);
    chk("result",        result,        m_result);
    chk("timeout_error", timeout_error, m_err);
    bad = -1;
    for (int i = N - 1; i >= 0; i--) if (inputs[i] !== m_vec[i]) bad = i;
    if (bad >= 0) chk("inputs_vec", inputs[bad], m_vec[bad]);
    else          chk("inputs_vec", 32'd0, 32'd0 + bad + 1);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input sample_t v);
    bit done;
    bit ok;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    for (int k = 0; k < 200 && !done; k++) begin
      ok = in_ready;
      tick;
      if (ok) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_bound", 32'd0, 32'd1);
  endtask

  task automatic send_vec(input sample_t v);
    for (int i = 0; i < N; i++) send(v);
  endtask

  // Responder: output_ready is seen on the d-th WAIT cycle when called in FIRE.
  task automatic respond(input int d, input sample_t v);
    repeat (d) tick;
    neuron_output_ready = 1'b1;
    neuron_out          = v;
    tick;
    neuron_output_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit at %0t", $time);
    $fatal(1, "time limit");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    neuron_out = '0;
    neuron_output_ready = 1'b0;
    result_ready = 1'b0;
    repeat (2) @(posedge clock);
    fork
      forever begin
        @(negedge clock);
        compare;
      end
    join_none
    #2;
    chk("rst_result",       result,        32'd0);
    chk("rst_result_valid", result_valid,  32'd0);
    chk("rst_inputs_ready", inputs_ready,  32'd0);
    chk("rst_busy",         busy,          32'd0);
    chk("rst_timeout",      timeout_error, 32'd0);
    chk("rst_inputs0",      inputs[0],     32'd0);
    tick;
    reset = 1'b0;

    // 1: sixteen 1.0 samples back to back, result 51.0 after 18 cycles
    send_vec(16'sh0100);
    chk("t1_fire",        inputs_ready, 32'd1);
    chk("t1_in_ready",    in_ready,     32'd0);
    respond(18, 16'sh3300);
    chk("t1_result",      result,       32'h3300);
    chk("t1_valid",       result_valid, 32'd1);
    chk("t1_vec15",       inputs[15],   32'h0100);
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;
    chk("t1_back_fill",   busy,         32'd0);

    // 2: values 0..15 with random gaps
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 3)) tick;
      send(sample_t'(i * 256));
    end
    chk("t2_fire",  inputs_ready, 32'd1);
    chk("t2_vec5",  inputs[5],    32'h0500);
    chk("t2_vec15", inputs[15],   32'h0f00);
    respond(3, 16'sh0a80);

    // 3: backpressure for 10 cycles with a sample waiting
    in_valid = 1'b1;
    in_data  = 16'sh7700;
    repeat (10) tick;
    chk("t3_result_held", result,   32'h0a80);
    chk("t3_in_ready",    in_ready, 32'd0);
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    chk("t3_vec0_new",  inputs[0], 32'h7700);
    chk("t3_vec1_kept", inputs[1], 32'h0100);

    // 4: spurious done pulses in FILL and PRESENT, then one-cycle PRESENT
    neuron_output_ready = 1'b1;
    neuron_out          = 16'sh5555;
    tick;
    neuron_output_ready = 1'b0;
    chk("t4_fill_nocap", result, 32'h0a80);
    for (int i = 1; i < N; i++) send(16'shfe00);
    chk("t4_vec0", inputs[0], 32'h7700);
    respond(5, 16'sh0123);
    neuron_output_ready = 1'b1;
    neuron_out          = 16'sh6666;
    tick;
    neuron_output_ready = 1'b0;
    chk("t4_present_nocap", result,       32'h0123);
    chk("t4_present_stay",  result_valid, 32'd1);
    result_ready = 1'b1;
    tick;
    send_vec(16'sh0080);
    respond(2, 16'sh0200);
    chk("t4_one_cycle_valid", result_valid, 32'd1);
    tick;
    chk("t4_one_cycle_done",  result_valid, 32'd0);
    result_ready = 1'b0;

    // 5: reset in WAIT and in PRESENT, then a normal vector
    send_vec(16'sh0300);
    repeat (5) tick;
    reset = 1'b1;
    #2;
    chk("t5w_busy",   busy,         32'd0);
    chk("t5w_result", result,       32'd0);
    chk("t5w_vec2",   inputs[2],    32'd0);
    chk("t5w_fire",   inputs_ready, 32'd0);
    tick;
    reset = 1'b0;
    send_vec(16'sh0100);
    respond(2, 16'sh0400);
    reset = 1'b1;
    #2;
    chk("t5p_valid",  result_valid, 32'd0);
    chk("t5p_result", result,       32'd0);
    tick;
    reset = 1'b0;
    send_vec(16'sh0200);
    respond(4, 16'sh1000);
    chk("t5_result", result, 32'h1000);
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;

`ifdef NEURON_DRIVER_TIMEOUT_EN
    // 6: done on exactly the last allowed cycle, then a silent neuron
    send_vec(16'sh0100);
    respond(TO, 16'sh0700);
    chk("t6_edge_result",  result,        32'h0700);
    chk("t6_edge_noerror", timeout_error, 32'd0);
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;
    send_vec(16'sh0100);
    repeat (TO + 1) tick;
    chk("t6_timeout",      timeout_error, 32'd1);
    chk("t6_back_fill",    busy,          32'd0);
    chk("t6_no_valid",     result_valid,  32'd0);
    chk("t6_result_kept",  result,        32'h0700);
`else
    // 6: silent neuron keeps the block in WAIT
    send_vec(16'sh0100);
    repeat (200) tick;
    chk("t6_still_busy", busy,          32'd1);
    chk("t6_no_error",   timeout_error, 32'd0);
    chk("t6_no_valid",   result_valid,  32'd0);
    respond(1, 16'sh0800);
    chk("t6_late_result", result, 32'h0800);
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;
`endif

    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
